// File: rtl/lcd_text_arbiter_if.sv
// Shared message-source bus for lcd_text_arbiter: requests, grant and the owner's write/commit strobes.
interface lcd_text_arbiter_if;
  logic [1:0] iREQ;
  logic [1:0] oGNT;
  logic       iWR;
  logic [4:0] iADDR;
  logic [7:0] iCHAR;
  logic       iDONE;

  modport master (output iREQ, iWR, iADDR, iCHAR, iDONE, input oGNT);
  modport slave  (input iREQ, iWR, iADDR, iCHAR, iDONE, output oGNT);
endinterface

// File: rtl/lcd_text_arbiter.sv
// Round-robin owner of the 2x16 LCD text: staging buffer, atomic commit, post-commit dwell.
// Optional idle-owner watchdog enabled by defining LCD_ARB_TIMEOUT_EN.
module lcd_text_arbiter #(
  parameter int unsigned        CNT_W          = 24,
  parameter logic [CNT_W-1:0]   HOLD_CYCLES    = 24'd5_000_000,
  parameter logic [CNT_W-1:0]   TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  lcd_text_arbiter_if.slave      bus,
  output logic                   oOWNER,
  output logic                   oBUSY,
  output logic [287:0]           oTEXT,
  output logic                   oCOMMIT
);

  localparam logic [8:0]       SPACE     = 9'h120;
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_CYCLES == '0) ? '0 : HOLD_CYCLES - 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_gnt;
  logic             r_owner;
  logic             r_commit;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [8:0]       r_stage [32];
  logic [8:0]       r_disp  [32];

  logic             w_start;
  logic             w_sel;
  logic             w_commit;
  logic             w_abort;
  logic             w_timeout;

`ifdef LCD_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES == '0) ? '0 : TIMEOUT_CYCLES - 1'b1;
  logic [CNT_W-1:0] r_to_cnt;

  // Any strobe from the owner restarts the watchdog, so a write on the limit cycle still counts.
  assign w_timeout = (r_state == S_GRANT) && !bus.iWR && (r_to_cnt == TO_LAST);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_to_cnt <= '0;
    end else if (r_state != S_GRANT || bus.iWR || bus.iDONE) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_sel       = r_owner;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|bus.iREQ) begin
          w_start     = 1'b1;
          w_sel       = (&bus.iREQ) ? ~r_owner : bus.iREQ[1];
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (bus.iDONE) begin
          w_commit    = 1'b1;
          w_state_nxt = (HOLD_CYCLES == '0) ? S_IDLE : S_HOLD;
        end else if (!bus.iREQ[r_owner] || w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_gnt      <= '0;
      r_owner    <= 1'b1;
      r_commit   <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_commit <= w_commit;
      if (w_start) begin
        r_gnt   <= w_sel ? 2'b10 : 2'b01;
        r_owner <= w_sel;
      end else if (w_commit || w_abort) begin
        r_gnt <= '0;
      end
      r_hold_cnt <= (r_state == S_HOLD && w_state_nxt == S_HOLD) ? r_hold_cnt + 1'b1 : '0;
    end
  end

  // The commit merges a same-cycle write so the last character is not lost.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int unsigned i = 0; i < 32; i++) begin
        r_stage[i] <= SPACE;
        r_disp[i]  <= SPACE;
      end
    end else begin
      if (w_start || w_abort) begin
        r_stage <= r_disp;
      end else if (r_state == S_GRANT && bus.iWR) begin
        r_stage[bus.iADDR] <= {1'b1, bus.iCHAR};
      end
      if (w_commit) begin
        for (int unsigned i = 0; i < 32; i++) begin
          r_disp[i] <= (bus.iWR && bus.iADDR == 5'(i)) ? {1'b1, bus.iCHAR} : r_stage[i];
        end
      end
    end
  end

  always_comb begin
    oTEXT = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      oTEXT[9*i +: 9] = r_disp[i];
    end
  end

  assign bus.oGNT = r_gnt;
  assign oOWNER   = r_owner;
  assign oBUSY    = (r_state != S_IDLE);
  assign oCOMMIT  = r_commit;

endmodule
